// File: rtl/timer_sync.sv
// Programmable frame timer: a fine counter runs 0..lim_q and advances a wide
// period counter on every wrap, with sync load, count enable and sticky overflow.
module timer_sync #(
   parameter int COUNTER  = 19,
   parameter int PERIOD_W = 48
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [COUNTER-1:0]  limit,
   input  logic                load,
   input  logic [PERIOD_W-1:0] load_period,
   output logic [COUNTER-1:0]  counter,
   output logic [PERIOD_W-1:0] period,
   output logic                period_done,
   output logic                period_ovf,
   output logic                synced
);

   // Terminal count is only taken from limit at a wrap or a load, so a frame
   // in flight always keeps the length it started with.
   logic [COUNTER-1:0] lim_q;
   logic               at_term;
   logic               period_max;

   assign at_term    = (counter == lim_q);
   assign period_max = &period;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         counter     <= '0;
         period      <= '0;
         lim_q       <= '1;
         period_done <= 1'b0;
         period_ovf  <= 1'b0;
         synced      <= 1'b0;
      end else if (load) begin
         counter     <= '0;
         period      <= load_period;
         lim_q       <= limit;
         period_done <= 1'b0;
         period_ovf  <= 1'b0;
         synced      <= 1'b1;
      end else if (!en) begin
         period_done <= 1'b0;
      end else if (at_term) begin
         counter     <= '0;
         period      <= period + PERIOD_W'(1);
         lim_q       <= limit;
         period_done <= 1'b1;
         if (period_max) begin
            period_ovf <= 1'b1;
         end
      end else begin
         counter     <= counter + COUNTER'(1);
         period_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_timer_sync.sv
// Self-checking bench for timer_sync: directed scenarios plus a randomized run
// compared against a cycle-level reference model of the frame timer.
module tb_timer_sync;
   localparam int CW   = 8;
   localparam int PW   = 8;
   localparam int CMOD = 1 << CW;
   localparam int PMOD = 1 << PW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          load = 1'b0;
   logic [CW-1:0] limit = '0;
   logic [PW-1:0] load_period = '0;
   logic [CW-1:0] counter;
   logic [PW-1:0] period;
   logic          period_done;
   logic          period_ovf;
   logic          synced;

   int tests = 0;
   int fails = 0;

   timer_sync #(.COUNTER(CW), .PERIOD_W(PW)) dut (
      .clk(clk), .rst(rst), .en(en), .limit(limit), .load(load),
      .load_period(load_period), .counter(counter), .period(period),
      .period_done(period_done), .period_ovf(period_ovf), .synced(synced)
   );

   always #5 clk = ~clk;

   // Reference model: frame position, frame number and flags as plain integers.
   int m_cnt, m_per, m_lim;
   bit m_done, m_ovf, m_sync;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt = 0; m_per = 0; m_lim = CMOD - 1;
         m_done = 0; m_ovf = 0; m_sync = 0;
      end else if (load) begin
         m_cnt = 0; m_per = int'(load_period); m_lim = int'(limit);
         m_done = 0; m_ovf = 0; m_sync = 1;
      end else if (!en) begin
         m_done = 0;
      end else if (m_cnt == m_lim) begin
         if (m_per + 1 == PMOD) m_ovf = 1;
         m_per  = (m_per + 1) % PMOD;
         m_cnt  = 0;
         m_lim  = int'(limit);
         m_done = 1;
      end else begin
         m_cnt  = m_cnt + 1;
         m_done = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_cnt(input int v, output bit ok);
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         if (int'(counter) == v) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (period_done) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; load = 1'b0; limit = 8'd4;
      #12;
      tests++;
      if ({counter, period, period_done, period_ovf, synced} !== '0) begin
         fails++;
         $display("FAIL reset_state: got cnt=%0d per=%0d done=%b ovf=%b sync=%b, want all 0",
                  counter, period, period_done, period_ovf, synced);
      end
      @(negedge clk);
      rst = 1'b1; en = 1'b1;
      tick();
      tests++;
      if (counter !== 8'd1 || period_done !== 1'b0 || period !== 8'd0) begin
         fails++;
         $display("FAIL reset_release: got cnt=%0d done=%b per=%0d, want cnt=1 done=0 per=0",
                  counter, period_done, period);
      end
   endtask

   task automatic test_first_frame();
      int n;
      int prev;
      n = 1;
      prev = int'(counter);
      while (!period_done && n < 600) begin
         prev = int'(counter);
         tick();
         n++;
      end
      tests++;
      if (n !== CMOD || prev !== CMOD - 1 || period !== 8'd1 || counter !== 8'd0) begin
         fails++;
         $display("FAIL first_frame: got len=%0d last=%0d per=%0d cnt=%0d, want len=%0d last=%0d per=1 cnt=0",
                  n, prev, period, counter, CMOD, CMOD - 1);
      end
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!period_done && n < 600);
         tests++;
         if (n !== 5 || period !== 8'(2 + k)) begin
            fails++;
            $display("FAIL frame_len4 %0d: got len=%0d per=%0d, want len=5 per=%0d", k, n, period, 2 + k);
         end
      end
   endtask

   task automatic test_limit_change();
      bit ok;
      int n;
      limit = 8'd9;
      wait_done(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL limchg_sync: got no pulse, want pulse");
      end
      n = 0;
      do begin
         tick();
         n++;
         if (counter === 8'd3) limit = 8'd2;
      end while (!period_done && n < 600);
      tests++;
      if (n !== 10) begin
         fails++;
         $display("FAIL limchg_hold: got spacing=%0d, want 10", n);
      end
      n = 0;
      do begin
         tick();
         n++;
      end while (!period_done && n < 600);
      tests++;
      if (n !== 3) begin
         fails++;
         $display("FAIL limchg_new: got spacing=%0d, want 3", n);
      end
   endtask

   task automatic test_load();
      bit ok;
      limit = 8'd9;
      wait_done(ok);
      wait_cnt(7, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL load_reach7: got timeout, want counter 7");
      end
      load = 1'b1; load_period = 8'hEF;
      tick();
      load = 1'b0;
      tests++;
      if (counter !== 8'd0 || period !== 8'hEF || synced !== 1'b1 || period_done !== 1'b0) begin
         fails++;
         $display("FAIL load_mid: got cnt=%0d per=%h sync=%b done=%b, want cnt=0 per=ef sync=1 done=0",
                  counter, period, synced, period_done);
      end
      wait_cnt(9, ok);
      load = 1'b1; load_period = 8'h5A;
      tick();
      load = 1'b0;
      tests++;
      if (!ok || counter !== 8'd0 || period !== 8'h5A || period_done !== 1'b0) begin
         fails++;
         $display("FAIL load_at_wrap: got cnt=%0d per=%h done=%b, want cnt=0 per=5a done=0",
                  counter, period, period_done);
      end
      tick();
      tests++;
      if (counter !== 8'd1 || period_done !== 1'b0 || period !== 8'h5A) begin
         fails++;
         $display("FAIL load_after: got cnt=%0d done=%b per=%h, want cnt=1 done=0 per=5a",
                  counter, period_done, period);
      end
   endtask

   task automatic test_enable();
      bit ok;
      logic [PW-1:0] p;
      limit = 8'd3;
      wait_done(ok);
      wait_cnt(2, ok);
      p = period;
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         tests++;
         if (!ok || counter !== 8'd2 || period !== p || period_done !== 1'b0) begin
            fails++;
            $display("FAIL en_hold %0d: got cnt=%0d per=%h done=%b, want cnt=2 per=%h done=0",
                     i, counter, period, period_done, p);
         end
      end
      en = 1'b1;
      tick();
      tests++;
      if (counter !== 8'd3 || period_done !== 1'b0) begin
         fails++;
         $display("FAIL en_resume3: got cnt=%0d done=%b, want cnt=3 done=0", counter, period_done);
      end
      tick();
      tests++;
      if (counter !== 8'd0 || period_done !== 1'b1 || period !== p + 8'd1) begin
         fails++;
         $display("FAIL en_resume_wrap: got cnt=%0d done=%b per=%h, want cnt=0 done=1 per=%h",
                  counter, period_done, period, p + 8'd1);
      end
   endtask

   task automatic test_overflow();
      logic [PW-1:0] exp_per [4];
      bit            exp_ovf [4];
      exp_per = '{8'hFF, 8'h00, 8'h01, 8'h02};
      exp_ovf = '{1'b0, 1'b1, 1'b1, 1'b1};
      limit = 8'd0; load = 1'b1; load_period = 8'hFE; en = 1'b1;
      tick();
      load = 1'b0;
      tests++;
      if (period !== 8'hFE || period_ovf !== 1'b0 || period_done !== 1'b0) begin
         fails++;
         $display("FAIL ovf_load: got per=%h ovf=%b done=%b, want per=fe ovf=0 done=0",
                  period, period_ovf, period_done);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (period !== exp_per[i] || period_ovf !== exp_ovf[i] || period_done !== 1'b1 || counter !== 8'd0) begin
            fails++;
            $display("FAIL ovf_step %0d: got per=%h ovf=%b done=%b cnt=%0d, want per=%h ovf=%b done=1 cnt=0",
                     i, period, period_ovf, period_done, counter, exp_per[i], exp_ovf[i]);
         end
      end
      en = 1'b0; load = 1'b1; load_period = 8'h10;
      tick();
      load = 1'b0;
      tests++;
      if (period_ovf !== 1'b0 || period !== 8'h10 || counter !== 8'd0 || period_done !== 1'b0) begin
         fails++;
         $display("FAIL ovf_clear: got ovf=%b per=%h cnt=%0d done=%b, want ovf=0 per=10 cnt=0 done=0",
                  period_ovf, period, counter, period_done);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         en          = ($urandom_range(0, 9) != 0);
         load        = ($urandom_range(0, 39) == 0);
         limit       = 8'($urandom_range(0, 6));
         load_period = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
         tick();
         tests++;
         if (int'(counter) !== m_cnt || int'(period) !== m_per || period_done !== m_done ||
             period_ovf !== m_ovf || synced !== m_sync) begin
            fails++;
            $display("FAIL random %0d: got cnt=%0d per=%0d done=%b ovf=%b sync=%b, want cnt=%0d per=%0d done=%b ovf=%b sync=%b",
                     i, counter, period, period_done, period_ovf, synced,
                     m_cnt, m_per, m_done, m_ovf, m_sync);
         end
      end
      load = 1'b0;
   endtask

   task automatic test_async_reset();
      limit = 8'd20; en = 1'b1; load = 1'b1; load_period = 8'd3;
      tick();
      load = 1'b0;
      repeat (5) tick();
      tests++;
      if (counter !== 8'd5 || period !== 8'd3) begin
         fails++;
         $display("FAIL arst_setup: got cnt=%0d per=%0d, want cnt=5 per=3", counter, period);
      end
      #2 rst = 1'b0;
      #1;
      tests++;
      if ({counter, period, period_done, period_ovf, synced} !== '0) begin
         fails++;
         $display("FAIL arst_clear: got cnt=%0d per=%0d done=%b ovf=%b sync=%b, want all 0",
                  counter, period, period_done, period_ovf, synced);
      end
      @(negedge clk);
      rst = 1'b1; en = 1'b1;
      tick();
      tests++;
      if (counter !== 8'd1 || period_done !== 1'b0 || period !== 8'd0 || synced !== 1'b0) begin
         fails++;
         $display("FAIL arst_release: got cnt=%0d done=%b per=%0d sync=%b, want cnt=1 done=0 per=0 sync=0",
                  counter, period_done, period, synced);
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_limit_change();
      test_load();
      test_enable();
      test_overflow();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
